// File: rtl/apb_uart_byte_pump.sv
// APB master that configures a CoreUARTapb after reset, then pumps bytes between
// valid/ready streams and the UART TX/RX data registers, paced by TXRDY/RXRDY.
module apb_uart_byte_pump #(
    parameter logic [12:0] BAUD_VALUE = 13'd1,
    parameter logic        PRG_BIT8   = 1'b1,
    parameter logic [1:0]  PRG_PARITY = 2'b00,
    parameter int unsigned GUARD      = 2
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    output logic [7:0] m_rdata,
    output logic       m_rvalid,
    input  logic       m_rready,
    input  logic       TXRDY,
    input  logic       RXRDY,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [4:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    output logic       init_done
);

    localparam logic [4:0] AddrTxData = 5'h00;
    localparam logic [4:0] AddrRxData = 5'h04;
    localparam logic [4:0] AddrCtrl1  = 5'h08;
    localparam logic [4:0] AddrCtrl2  = 5'h0C;
    localparam logic [2:0] GuardVal   = 3'(GUARD);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;
    typedef enum logic [2:0] {OpNone, OpInit1, OpInit2, OpRx, OpTx} op_e;

    state_e      state_q;
    op_e         op_q;
    op_e         next_op;
    logic        psel_q, penable_q, pwrite_q;
    logic [4:0]  paddr_q;
    logic [7:0]  pwdata_q;
    logic        init1_q, init_done_q;
    logic [7:0]  tx_data_q, rx_data_q;
    logic        tx_valid_q, rx_valid_q;
    logic [2:0]  tx_guard_q, rx_guard_q;

    // Packs {PWRITE, PADDR, PWDATA} for the op about to enter SETUP.
    function automatic logic [13:0] op_bus(input op_e op);
        logic [13:0] bus;
        bus = '0;
        case (op)
            OpInit1: bus = {1'b1, AddrCtrl1, BAUD_VALUE[7:0]};
            OpInit2: bus = {1'b1, AddrCtrl2, BAUD_VALUE[12:8], PRG_PARITY, PRG_BIT8};
            OpRx:    bus = {1'b0, AddrRxData, 8'h00};
            OpTx:    bus = {1'b1, AddrTxData, tx_data_q};
            default: bus = '0;
        endcase
        return bus;
    endfunction

    always_comb begin
        next_op = OpNone;
        if (!init1_q) begin
            next_op = OpInit1;
        end else if (!init_done_q) begin
            next_op = OpInit2;
        end else if (RXRDY && !rx_valid_q && (rx_guard_q == 3'd0)) begin
            next_op = OpRx;
        end else if (tx_valid_q && TXRDY && (tx_guard_q == 3'd0)) begin
            next_op = OpTx;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= StIdle;
            op_q        <= OpNone;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            init1_q     <= 1'b0;
            init_done_q <= 1'b0;
            tx_data_q   <= '0;
            rx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_guard_q  <= '0;
            rx_guard_q  <= '0;
        end else begin
            if (tx_guard_q != 3'd0) tx_guard_q <= tx_guard_q - 3'd1;
            if (rx_guard_q != 3'd0) rx_guard_q <= rx_guard_q - 3'd1;
            if (s_tvalid && s_tready) begin
                tx_data_q  <= s_tdata;
                tx_valid_q <= 1'b1;
            end
            if (rx_valid_q && m_rready) rx_valid_q <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (next_op != OpNone) begin
                        state_q                        <= StSetup;
                        op_q                           <= next_op;
                        psel_q                         <= 1'b1;
                        {pwrite_q, paddr_q, pwdata_q}  <= op_bus(next_op);
                    end
                end
                StSetup: begin
                    state_q   <= StAccess;
                    penable_q <= 1'b1;
                end
                StAccess: begin
                    if (PREADY) begin
                        penable_q <= 1'b0;
                        case (op_q)
                            OpInit1: init1_q <= 1'b1;
                            OpInit2: init_done_q <= 1'b1;
                            OpRx: begin
                                rx_data_q  <= PRDATA;
                                rx_valid_q <= 1'b1;
                                rx_guard_q <= GuardVal;
                            end
                            OpTx: begin
                                tx_valid_q <= 1'b0;
                                tx_guard_q <= GuardVal;
                            end
                            default: ;
                        endcase
                        // The two config writes run back to back so init finishes in 4 cycles.
                        if (op_q == OpInit1) begin
                            state_q                       <= StSetup;
                            op_q                          <= OpInit2;
                            {pwrite_q, paddr_q, pwdata_q} <= op_bus(OpInit2);
                        end else begin
                            state_q <= StIdle;
                            psel_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign init_done = init_done_q;
    assign s_tready  = init_done_q & ~tx_valid_q;
    assign m_rvalid  = rx_valid_q;
    assign m_rdata   = rx_data_q;

endmodule
